// File: rtl/cp0_unit_pkg.sv
// Coprocessor-0 shared definitions: register addresses, field positions,
// and exception codes.
package cp0_unit_pkg;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EC_HI   = 6;
  localparam int EC_LO   = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, exception and interrupt request,
// mfc0/mtc0/eret servicing.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h2023_0007,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        we,
  input  logic        EXLClr,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic        Req,
  output logic [31:0] HandlerPC
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr;
  logic [31:0] cause;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
  assign Req     = int_req | exc_req;

  // eret outranks mtc0 when both appear without a request
  assign wr_sr  = we & ~EXLClr & (A2 == ADDR_SR);
  assign wr_epc = we & ~EXLClr & (A2 == ADDR_EPC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (Req) begin
      exl <= 1'b1;
    end else if (EXLClr) begin
      exl <= 1'b0;
    end else if (wr_sr) begin
      im  <= Din[IM_HI:IM_LO];
      exl <= Din[EXL_BIT];
      ie  <= Din[IE_BIT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        bd       <= BDIn;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc <= '0;
    end else if (Req) begin
      epc <= BDIn ? VPC - 32'd4 : VPC;
    end else if (wr_epc) begin
      epc <= Din;
    end
  end

  always_comb begin
    sr = '0;
    sr[IM_HI:IM_LO] = im;
    sr[EXL_BIT]     = exl;
    sr[IE_BIT]      = ie;
  end

  always_comb begin
    cause = '0;
    cause[BD_BIT]      = bd;
    cause[IP_HI:IP_LO] = ip;
    cause[EC_HI:EC_LO] = exc_code;
  end

  always_comb begin
    Dout = '0;
    case (A1)
      ADDR_SR:    Dout = sr;
      ADDR_CAUSE: Dout = cause;
      ADDR_EPC:   Dout = epc;
      ADDR_PRID:  Dout = PRID_VAL;
      default:    Dout = '0;
    endcase
  end

  assign EPCOut    = epc;
  assign HandlerPC = HANDLER_PC;

endmodule
